// File: rtl/mux_arb_pkg.sv
// Shared types, widths and round-robin helpers for the 8-way mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req scanning ptr, ptr+1, ... ptr+7 (mod 8).
  function automatic rr_pick_t rr_next(input logic [N_REQ-1:0] req,
                                       input logic [SEL_W-1:0] ptr);
    rr_pick_t         r;
    logic [SEL_W-1:0] i;
    r = '0;
    // Scan from the far end so the closest match to ptr is written last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      i = ptr + SEL_W'(k);
      if (req[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_1.sv
// 8:1 single-bit datapath mux driven by the arbiter's select.
import mux_arb_pkg::*;

module mux8_1 (
  input  logic [N_REQ-1:0] d,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  assign y = d[sel];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter in front of an 8:1 mux; optional hold limit with
// forced rotation is compiled in when MUX_ARB_HOLD_EN is defined.
import mux_arb_pkg::*;

module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             y,
  output logic             y_valid
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("mux8_rr_arbiter: MAX_HOLD must be 1..15 and fit in CNT_W bits");
  end

  arb_state_e       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_after;
  logic [N_REQ-1:0] others;
  rr_pick_t         pick_idle;
  rr_pick_t         pick_next;

  // Candidates: fresh arbitration from ptr, or handover past the current owner.
  always_comb begin
    ptr_after = sel + SEL_W'(1);
    others    = req & ~gnt;
    pick_idle = rr_next(req, ptr);
    pick_next = rr_next(others, ptr_after);
  end

`ifdef MUX_ARB_HOLD_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_limit;

  always_comb hold_limit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      y_valid <= 1'b0;
      ptr     <= '0;
`ifdef MUX_ARB_HOLD_EN
      hold_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle.found) begin
            state   <= GRANT;
            gnt     <= onehot(pick_idle.idx);
            sel     <= pick_idle.idx;
            y_valid <= 1'b1;
`ifdef MUX_ARB_HOLD_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (!req[sel]) begin
            // Release: hand over without a bubble, or go idle keeping sel.
            ptr <= ptr_after;
            if (pick_next.found) begin
              gnt <= onehot(pick_next.idx);
              sel <= pick_next.idx;
`ifdef MUX_ARB_HOLD_EN
              hold_cnt <= '0;
`endif
            end else begin
              state   <= IDLE;
              gnt     <= '0;
              y_valid <= 1'b0;
            end
          end
`ifdef MUX_ARB_HOLD_EN
          else if (hold_limit) begin
            // Forced rotation only if someone else is waiting.
            hold_cnt <= '0;
            if (pick_next.found) begin
              ptr <= ptr_after;
              gnt <= onehot(pick_next.idx);
              sel <= pick_next.idx;
            end
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          state   <= IDLE;
          gnt     <= '0;
          y_valid <= 1'b0;
        end
      endcase
    end
  end

  mux8_1 u_mux (
    .d  (d),
    .sel(sel),
    .y  (y)
  );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_mux8_rr_arbiter;

  localparam int unsigned MAXH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] d;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       y;
  logic       y_valid;

  mux8_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .d      (d),
    .gnt    (gnt),
    .sel    (sel),
    .y      (y),
    .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  // Model state: who owns the mux, where priority starts, how long held.
  int m_busy = 0;
  int m_sel  = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;

  function automatic int pick(input logic [7:0] r, input int from);
    for (int k = 0; k < 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on each edge, then compare the DUT just after the edge.
  always @(posedge clk) begin : model
    logic [7:0] r;
    logic [7:0] exp_gnt;
    int         w;
    r = req;
    if (rst) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_busy == 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_sel = w; m_cnt = 0;
      end
    end else if (!r[m_sel]) begin
      m_ptr = (m_sel + 1) % 8;
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_sel = w; m_cnt = 0;
      end else begin
        m_busy = 0;
      end
    end else begin
`ifdef MUX_ARB_HOLD_EN
      if (m_cnt == int'(MAXH) - 1) begin
        m_cnt = 0;
        r[m_sel] = 1'b0;
        w = pick(r, (m_sel + 1) % 8);
        if (w >= 0) begin
          m_ptr = (m_sel + 1) % 8;
          m_sel = w;
        end
      end else begin
        m_cnt++;
      end
`endif
    end
    #1;
    if (armed) begin
      exp_gnt = (m_busy != 0) ? 8'(1 << m_sel) : 8'h00;
      chk("model_gnt", gnt, exp_gnt);
      chk("model_sel", 8'(sel), 8'(m_sel));
      chk("model_y_valid", 8'(y_valid), 8'(m_busy));
      chk("model_y", 8'(y), 8'(d[m_sel]));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_h;
    rst = 1'b1;
    req = 8'hFF;
    d   = 8'h00;
    cyc(); cyc();
    armed = 1'b1;
    chk("reset_gnt", gnt, 8'h00);
    chk("reset_sel", 8'(sel), 8'h00);
    chk("reset_y_valid", 8'(y_valid), 8'h00);
    rst = 1'b0;
    cyc();
    chk("first_grant_gnt", gnt, 8'h01);
    chk("first_grant_sel", 8'(sel), 8'h00);

    // Single requester.
    req = 8'h00; cyc();
    d = 8'b1010_1010; req = 8'h20; cyc();
    chk("single_gnt", gnt, 8'h20);
    chk("single_sel", 8'(sel), 8'h05);
    chk("single_y", 8'(y), 8'h01);
    chk("single_y_valid", 8'(y_valid), 8'h01);
    req = 8'h00; cyc();
    chk("single_drop_valid", 8'(y_valid), 8'h00);
    chk("single_drop_sel", 8'(sel), 8'h05);

    // Rotation between 0 and 7 with pointer wrap.
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 8'h81; cyc();
    chk("rot_0a", gnt, 8'h01);
    req = 8'h80; cyc();
    chk("rot_7a", gnt, 8'h80);
    req = 8'h81; cyc();
    req = 8'h01; cyc();
    chk("rot_0b_wrap", gnt, 8'h01);
    req = 8'h81; cyc();
    req = 8'h80; cyc();
    chk("rot_7b", gnt, 8'h80);

    // Hold limit behaviour with two contenders.
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 8'h0C;
    for (int k = 0; k < 16; k++) begin
      cyc();
`ifdef MUX_ARB_HOLD_EN
      exp_h = (((k / int'(MAXH)) % 2) != 0) ? 8'h08 : 8'h04;
`else
      exp_h = 8'h04;
`endif
      chk("hold_gnt", gnt, exp_h);
    end

    // Lone owner never loses the grant.
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 8'h02;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("lone_gnt", gnt, 8'h02);
    end

    // Reset mid-grant, then re-grant from ptr 0.
    req = 8'h00; cyc();
    req = 8'h10; cyc();
    chk("midrst_pre", gnt, 8'h10);
    rst = 1'b1; cyc();
    chk("midrst_gnt", gnt, 8'h00);
    chk("midrst_valid", 8'(y_valid), 8'h00);
    rst = 1'b0; cyc();
    chk("midrst_regrant", gnt, 8'h10);
    chk("midrst_sel", 8'(sel), 8'h04);

    // Randomized traffic with sticky requests and rare resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom & $urandom);
      else if ($urandom_range(0, 7) == 0) req = 8'hFF;
      d = 8'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares the 8:1 single-bit mux between eight requesters. Each requester presents one data bit on `d` and raises its `req` bit; the arbiter grants one requester at a time, drives the mux select, and exposes the selected bit with a valid flag. It sits directly in front of the 8:1 mux and is the only block that drives its select lines.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one owner while others wait. Range 1..15.
- `CNT_W`, default 4: width of the hold counter. Must satisfy `2**CNT_W > MAX_HOLD`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request per requester; level-sensitive.
- `d`  in  8  data bit per requester; `d[i]` belongs to requester i.
- `gnt`  out  8  one-hot grant, registered; all zero when idle.
- `sel`  out  3  mux select, registered; equals the index of the set `gnt` bit.
- `y`  out  1  selected data, combinational: `d[sel]`.
- `y_valid`  out  1  registered; high while any grant is active.

## Operation
- Two-state FSM:
  - IDLE: `gnt` = 0 and `y_valid` = 0.
  - GRANT: exactly one `gnt` bit is set and `y_valid` = 1.
- Rotating pointer `ptr` (3 bits) holds the highest-priority index.
  - The winner is the first set `req` bit scanning `ptr`, `ptr+1`, …, `ptr+7` (mod 8).
- IDLE → GRANT: any `req` bit is high.
  - Load `gnt` and `sel` with the winner.
  - Clear the hold counter.
- GRANT, owner's `req` high, hold limit not reached: keep the grant and increment the hold counter.
- GRANT, owner's `req` low (release):
  - Set `ptr` = owner+1.
  - If any other `req` is high, grant the next winner in the same edge (no idle bubble).
  - Otherwise go to IDLE. `sel` holds its last value.
- Forced rotation (see Configuration): when the hold counter reaches `MAX_HOLD`-1 and another `req` is high:
  - Set `ptr` = owner+1 and grant the next winner in the same edge.
- No other `req` at the hold limit: the owner keeps the grant and the counter restarts at 0.
- Pointer wrap: owner 7 releases → `ptr` = 0.
- Owner deasserts `req` while re-requesting in the same cycle: not possible (one bit per requester). A deasserted owner loses priority to the others for one arbitration.
- `gnt` is never multi-hot. `sel` only changes on an arbitration edge.

## Timing
- Reset values: `gnt` = 8'h00, `sel` = 3'd0, `y_valid` = 0, `ptr` = 0, hold counter = 0, FSM = IDLE. `y` follows `d[0]`.
- Grant latency: `req` sampled high at edge N → `gnt`/`sel`/`y_valid` valid after edge N+1.
- Release latency: owner `req` sampled low at edge N → the new grant or idle takes effect after edge N+1.
- `y` is valid in the same cycle `sel` updates; it has a combinational path from `d`.
- Reset asserted during GRANT: all outputs return to reset values after the next edge. `ptr` returns to 0.
- Simultaneous requests from all eight: each requester is granted in order from `ptr`, one grant per release or forced rotation.

## Configuration
- `MUX_ARB_HOLD_EN` defined:
  - Hold counter and forced rotation are compiled in.
  - The maximum wait for any requester is 7×`MAX_HOLD` cycles.
- Undefined:
  - No hold counter.
  - The owner keeps the grant until it deasserts `req` (lock-until-release).
  - `MAX_HOLD` and `CNT_W` are ignored.

## Structure
- Shared package `mux_arb_pkg`:
  - FSM state typedef (IDLE, GRANT).
  - Constant `N_REQ` = 8.
  - Constant `SEL_W` = 3.
  - Round-robin next-winner function (`req`, `ptr` → index, found).
- One sub-module: `mux8_1`, instantiated with `.d(d)`, `.sel(sel)`, `.y(y)`. It provides the datapath. The arbiter contains no mux logic of its own.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=8'hFF → `gnt`=0, `sel`=0, `y_valid`=0. Release reset → after edge 1, `gnt`=8'h01, `sel`=0.
- Single requester: `req`=8'h20, `d`=8'b10101010 → after 1 edge, `gnt`=8'h20, `sel`=5, `y`=1, `y_valid`=1. Drop `req` → after 1 edge, `y_valid`=0 and `sel` stays 5.
- Rotation: `req`=8'h81 constant, define off, release by pulsing each owner's `req` low one cycle → grant order 0, 7, 0, 7; `ptr` wraps 7→0.
- Hold limit: `MUX_ARB_HOLD_EN` defined, `MAX_HOLD`=4, `req`=8'h0C held → `gnt` alternates 8'h04 ×4 cycles, 8'h08 ×4 cycles. Without the define, `gnt` stays 8'h04 indefinitely.
- Lone owner at limit: define on, `req`=8'h02 only for 10 cycles → `gnt`=8'h02 throughout, no glitch to 0.
- Reset mid-grant: `req`=8'h10 granted, assert `rst` one cycle → next edge `gnt`=0. After release, re-grant to index 4 with `ptr` starting at 0.
